// File: rtl/qr_row_feeder_if.sv
// Handshake and data bundle between an element source, the row feeder and
// the QR core. The feeder itself uses the slave modport.
interface qr_row_feeder_if #(
    parameter int D_WIDTH    = 4,
    parameter int DATA_WIDTH = 20
);
    logic                          in_valid;
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic [DATA_WIDTH*D_WIDTH-1:0] out_row;
    logic                          done_i;
    logic                          busy;

    // Source / QR-core side.
    modport master (
        output in_valid, in_data, done_i,
        input  in_ready, out_valid, out_row, busy
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_data, done_i,
        output in_ready, out_valid, out_row, busy
    );
endinterface

// File: rtl/qr_row_feeder.sv
// Double-buffered matrix feeder for a QR core. Elements arrive one per
// accepted handshake in row-major order and fill one of two banks; a full
// bank is replayed to the core as ROWS back-to-back packed rows, then held
// until the core signals done_i, which frees the bank for the writer.
module qr_row_feeder #(
    parameter int D_WIDTH    = 4,
    parameter int DATA_WIDTH = 20,
    parameter int ROWS       = 8
) (
    input  logic               clk,
    input  logic               rst,
    qr_row_feeder_if.slave     bus
);
    localparam int N_ELEM   = ROWS * D_WIDTH;
    localparam int CNT_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_BITS = DATA_WIDTH * D_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WAIT_DONE
    } rd_state_e;

    rd_state_e             state_q, state_d;
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [ROW_W-1:0]      rd_row_q, rd_row_d;
    logic                  out_valid_q, out_valid_d;
    logic [ROW_BITS-1:0]   out_row_q, out_row_d;

    // Elements are stored as raw bit patterns; no arithmetic is done on
    // them, so signedness never comes into play and data passes unchanged.
    logic [DATA_WIDTH-1:0] mem_q [2][N_ELEM];

    logic in_ready;
    logic accept;

    // The writer may only fill a bank the reader has released.
    assign in_ready      = !rst && !full_q[wr_bank_q];
    assign accept        = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.busy      = (|full_q) || (wr_cnt_q != '0) || (state_q != IDLE);

    // Next-state logic: write pointer/count, bank flags and the read FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_row_d    = rd_row_q;
        out_valid_d = 1'b0;
        out_row_d   = out_row_q;

        // Write side: the last element of a matrix seals the bank.
        if (accept) begin
            if (wr_cnt_q == CNT_W'(N_ELEM - 1)) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end

        // Read side. The writer only ever touches an empty bank and the
        // reader only releases a full one, so both flag updates can land
        // on the same edge without conflict.
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = BURST;
                    rd_row_d = '0;
                end
            end
            BURST: begin
                out_valid_d = 1'b1;
                for (int c = 0; c < D_WIDTH; c++) begin
                    out_row_d[ROW_BITS-1-c*DATA_WIDTH -: DATA_WIDTH] =
                        mem_q[rd_bank_q][CNT_W'(int'(rd_row_q) * D_WIDTH + c)];
                end
                if (rd_row_q == ROW_W'(ROWS - 1)) begin
                    state_d = WAIT_DONE;
                end else begin
                    rd_row_d = rd_row_q + ROW_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.done_i) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_row_q    <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_row_q    <= rd_row_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
        end
    end

    // Bank storage: written on every accepted element.
    always_ff @(posedge clk) begin
        // NOTE: the banks are deliberately not reset; the FULL flags guard every read.
        if (accept) begin
            mem_q[wr_bank_q][wr_cnt_q] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_qr_row_feeder.sv
// Self-checking bench for qr_row_feeder. A transaction-level model tracks
// completed matrices, their completion/release edges and the row burst
// timing; every cycle in_ready, out_valid, out_row and busy are compared.
module tb_qr_row_feeder;
    localparam int D = 4;
    localparam int W = 20;
    localparam int R = 8;
    localparam int N = R * D;

    logic clk;
    logic rst;

    qr_row_feeder_if #(.D_WIDTH(D), .DATA_WIDTH(W)) bus ();

    qr_row_feeder #(.D_WIDTH(D), .DATA_WIDTH(W), .ROWS(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int             e          = 0;     // rising-edge counter
    int             full_cnt   = 0;     // sealed, unreleased matrices
    int             wr_cnt     = 0;     // elements of the partial matrix
    int             head_start = -1;    // edge the head matrix became issuable
    int             last_rel   = -1000; // edge of the latest release
    int             comp_edge[$];       // completion edge per sealed matrix
    logic [W-1:0]   mdata[$];           // all buffered elements, FIFO order
    logic [D*W-1:0] last_row   = '0;
    bit             acc;
    bit             exp_valid;
    int             exp_rowidx;

    logic [W-1:0]   tx[$];              // elements still to be offered

    task automatic check(input string tag, input logic [D*W-1:0] obs,
                         input logic [D*W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model on
    // the edge, then check the registered outputs one time unit later.
    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic dn, input logic r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.done_i   = dn;
        rst          = r;
        #1;
        check("in_ready", {79'd0, bus.in_ready}, {79'd0, (!r && full_cnt < 2)});
        acc = v && !r && (full_cnt < 2);
        @(posedge clk);
        e++;
        if (r) begin
            full_cnt   = 0;
            wr_cnt     = 0;
            head_start = -1;
            last_rel   = -1000;
            comp_edge.delete();
            mdata.delete();
            last_row   = '0;
        end else begin
            if (acc) begin
                mdata.push_back(d);
                wr_cnt++;
                if (wr_cnt == N) begin
                    wr_cnt = 0;
                    full_cnt++;
                    comp_edge.push_back(e);
                end
            end
            // done_i only counts once the whole burst has been issued.
            if (dn && head_start >= 0 && e >= head_start + R + 2) begin
                repeat (N) void'(mdata.pop_front());
                void'(comp_edge.pop_front());
                full_cnt--;
                last_rel   = e;
                head_start = -1;
            end
            if (head_start < 0 && comp_edge.size() > 0)
                head_start = (comp_edge[0] > last_rel) ? comp_edge[0] : last_rel;
        end
        exp_valid = !r && head_start >= 0 && e >= head_start + 2 &&
                    e <= head_start + R + 1;
        if (exp_valid) begin
            exp_rowidx = e - head_start - 2;
            for (int c = 0; c < D; c++)
                last_row[(D-1-c)*W +: W] = mdata[exp_rowidx*D + c];
        end
        #1;
        check("out_valid", {79'd0, bus.out_valid}, {79'd0, exp_valid});
        check("out_row", bus.out_row, last_row);
        check("busy", {79'd0, bus.busy}, {79'd0, (full_cnt != 0 || wr_cnt != 0)});
    endtask

    // Offer queued elements with the given valid probability (percent);
    // pulse done_i every done_every cycles when non-zero.
    task automatic feed(input int cycles, input int vprob, input int done_every);
        for (int k = 0; k < cycles; k++) begin
            logic         v;
            logic [W-1:0] d;
            logic         dn;
            v  = (tx.size() > 0) && ($urandom_range(99) < vprob);
            d  = v ? tx[0] : W'($urandom);
            dn = (done_every > 0) && (((k + 1) % done_every) == 0);
            step(v, d, dn, 1'b0);
            if (acc) void'(tx.pop_front());
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic load_random(input int count);
        for (int i = 0; i < count; i++) tx.push_back(W'($urandom));
    endtask

    initial begin
        int guard;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.done_i   = 1'b0;
        rst          = 1'b1;

        // Reset state.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("reset_out_row", bus.out_row, '0);

        // Ascending 1..32 streamed without gaps.
        for (int i = 1; i <= N; i++) tx.push_back(W'(i));
        feed(N, 100, 0);
        idle(2);
        check("asc_row0_valid", {79'd0, bus.out_valid}, 80'd1);
        check("asc_row0", bus.out_row, 80'h00001_00002_00003_00004);
        idle(10);
        check("asc_row7_hold", bus.out_row, 80'h0001D_0001E_0001F_00020);
        check("asc_wait_busy", {79'd0, bus.busy}, 80'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Negative elements, plus a done_i pulse during the burst.
        for (int i = 1; i <= N; i++) tx.push_back(W'(-i));
        feed(N, 100, 0);
        idle(2);
        check("neg_row0", bus.out_row, 80'hFFFFF_FFFFE_FFFFD_FFFFC);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(10);
        check("neg_done_ignored_busy", {79'd0, bus.busy}, 80'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Three matrices back to back with no done_i: writer stalls.
        load_random(3 * N);
        feed(120, 100, 0);
        check("b2b_stalled_ready", {79'd0, bus.in_ready}, 80'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("b2b_ready_after_done", {79'd0, bus.in_ready}, 80'd1);
        feed(300, 100, 20);
        check("b2b_drained_busy", {79'd0, bus.busy}, 80'd0);

        // Randomly gapped valid during load.
        load_random(N);
        feed(250, 40, 0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Partial matrix is never issued.
        load_random(10);
        feed(10, 100, 0);
        idle(20);
        check("partial_no_valid", {79'd0, bus.out_valid}, 80'd0);
        check("partial_busy", {79'd0, bus.busy}, 80'd1);

        // Complete it, then reset on burst row 3.
        load_random(N - 10);
        feed(N - 10, 100, 0);
        guard = 0;
        while (!(exp_valid && exp_rowidx == 3) && guard < 20) begin
            idle(1);
            guard++;
        end
        check("row3_reached", {79'd0, bus.out_valid}, 80'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("rst_mid_burst_valid", {79'd0, bus.out_valid}, 80'd0);
        check("rst_mid_burst_busy", {79'd0, bus.busy}, 80'd0);
        idle(1);
        check("ready_after_reset", {79'd0, bus.in_ready}, 80'd1);

        // Fresh matrix after reset.
        load_random(N);
        feed(45, 100, 0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/qr_row_feeder.md
QR_ROW_FEEDER -- requirements
Module: qr_row_feeder

Interface
REQ-001 Parameter D_WIDTH, default 4, number of matrix columns (elements per row).
REQ-002 Parameter DATA_WIDTH, default 20, signed element width in bits.
REQ-003 Parameter ROWS, default 8, number of matrix rows per matrix.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset; one clock, sampled on rising edge of clk.
REQ-006 in_valid  input  1  upstream element valid.
REQ-007 in_data  input  DATA_WIDTH  signed matrix element; row-major order (row 0 col 0 first).
REQ-008 in_ready  output  1  feeder can accept in_data this cycle.
REQ-009 out_valid  output  1  row valid to QR core (drives its valid_i).
REQ-010 out_row  output  DATA_WIDTH*D_WIDTH  packed row to QR core (drives its a_ij).
REQ-011 done_i  input  1  one-cycle pulse from QR core side: current matrix fully processed.
REQ-012 busy  output  1  any matrix buffered or in flight.

Function
REQ-013 The block SHALL hold two matrix banks (0, 1), each ROWS*D_WIDTH elements, with per-bank flag FULL/EMPTY.
REQ-014 Write side: pointer wr_bank; in_ready SHALL equal (!rst && bank[wr_bank]==EMPTY), combinational.
REQ-015 Element accepted when in_valid && in_ready; stored at index wr_cnt of bank[wr_bank]; wr_cnt increments by 1.
REQ-016 On accept with wr_cnt == ROWS*D_WIDTH-1: bank[wr_bank] becomes FULL, wr_cnt wraps to 0, wr_bank toggles, all at that edge.
REQ-017 Read FSM states: IDLE, BURST, WAIT_DONE; pointer rd_bank; row counter rd_row.
REQ-018 IDLE -> BURST when bank[rd_bank]==FULL; rd_row set to 0.
REQ-019 In BURST: out_valid=1 for exactly ROWS consecutive cycles, no gaps, rows 0..ROWS-1 in order; after row ROWS-1 -> WAIT_DONE.
REQ-020 Packing: column 0 in out_row[DATA_WIDTH*D_WIDTH-1 -: DATA_WIDTH], column D_WIDTH-1 in bits [DATA_WIDTH-1:0].
REQ-021 out_valid and out_row SHALL be registered; out_row holds last row value when out_valid is 0.
REQ-022 Latency: if last element of a matrix is accepted at edge N and read FSM is IDLE on that bank, first out_valid high sampled at edge N+2 (registered IDLE->BURST, then registered output), last at edge N+ROWS+1.
REQ-023 WAIT_DONE -> IDLE on done_i: bank[rd_bank] becomes EMPTY, rd_bank toggles at that edge.
REQ-024 done_i in IDLE or BURST SHALL be ignored (no state change).
REQ-025 Simultaneous write-complete on one bank and done_i release of the other: both updates SHALL take effect in the same edge.
REQ-026 Both banks FULL: in_ready=0 until done_i frees a bank; in_ready returns to 1 the cycle after done_i.
REQ-027 Partial matrix (wr_cnt>0) SHALL never be issued; it waits for remaining elements indefinitely.
REQ-028 busy SHALL be 1 when any bank FULL, wr_cnt != 0, or FSM != IDLE; else 0.
REQ-029 Element data SHALL pass unmodified (no sign change, rounding or truncation).

Reset
REQ-030 With rst=1 at a rising edge: FSM=IDLE, both banks EMPTY, wr_bank=rd_bank=0, wr_cnt=rd_row=0, out_valid=0, out_row=0, busy=0.
REQ-031 Reset mid-load or mid-burst SHALL discard all buffered data; out_valid low the cycle after reset edge; no partial burst resumes.
REQ-032 Bank storage contents need not be reset.

Verification
REQ-033 Stream elements 1..32 continuously -> in_ready stays 1; 8 contiguous out_valid cycles; row 0 = 0x00001_00002_00003_00004, row 7 = 0x0001D_0001E_0001F_00020.
REQ-034 Elements -1..-32 -> row 0 = 0xFFFFF_FFFFE_FFFFD_FFFFC (sign preserved).
REQ-035 Stream 3 matrices back-to-back, no done_i -> first burst issued, in_ready drops after 64th element; done_i pulse -> second burst starts, in_ready high next cycle.
REQ-036 Toggle in_valid randomly during load -> no burst until 32nd accept; out_valid timing per REQ-022.
REQ-037 done_i pulsed during BURST -> ignored, FSM still waits; second done_i in WAIT_DONE -> bank released.
REQ-038 Assert rst at burst row 3 -> out_valid 0 next cycle, busy 0, in_ready 1 after reset released; fresh matrix issues normally.
